mult_hilo_sequencer: RTL and testbench

- Multi-cycle iterative multiplier with its HI/LO register pair, sitting beside the EX stage.
- EX launches MULT/MULTU (funct 0x18/0x19); these write no GPR, so the result lands in HI/LO only.
- MFHI/MFLO (funct 0x10/0x12) read HI/LO through this block.
- Drives a pipeline stall interlock while a multiply is in flight and a dependent or conflicting op arrives.

---
 rtl/mult_hilo_sequencer.sv | 140 ++++++++++++++
 tb/tb_mult_hilo_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_hilo_sequencer.sv
// Iterative shift-add multiplier with HI/LO register pair and EX-stage stall interlock.
// Optional MTHI/MTLO write path enabled by defining MULT_HILO_MTHILO_EN.
module mult_hilo_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  input  logic             start_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  input  logic             mfhi_req,
  input  logic             mflo_req,
`ifdef MULT_HILO_MTHILO_EN
  input  logic             mthi_req,
  input  logic             mtlo_req,
  input  logic [WIDTH-1:0] mt_data,
`endif
  output logic [WIDTH-1:0] mf_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic                 req_any;

  // Magnitudes for signed operands; -2^(W-1) maps onto itself, which is correct as unsigned.
  assign abs_a = (start_signed && op_a[WIDTH-1]) ? (~op_a + WIDTH'(1)) : op_a;
  assign abs_b = (start_signed && op_b[WIDTH-1]) ? (~op_b + WIDTH'(1)) : op_b;

`ifdef MULT_HILO_MTHILO_EN
  assign req_any = start_valid | mfhi_req | mflo_req | mthi_req | mtlo_req;
`else
  assign req_any = start_valid | mfhi_req | mflo_req;
`endif

  assign busy    = (state_q != S_IDLE);
  assign stall   = busy & req_any & ~flush;
  assign done    = (state_q == S_FIX);
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign mf_data = mfhi_req ? hi_q : lo_q;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    sum      = '0;
    prod     = '0;

    case (state_q)
      S_IDLE: begin
        if (start_valid && !flush) begin
          mcand_d  = abs_a;
          mplier_d = abs_b;
          neg_d    = start_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
`ifdef MULT_HILO_MTHILO_EN
        else if (!flush) begin
          if (mthi_req) hi_d = mt_data;
          if (mtlo_req) lo_d = mt_data;
        end
`endif
      end

      S_RUN: begin
        // Carry out of the upper-half add becomes the new MSB after the shift.
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
        acc_d    = {sum, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end

      S_FIX: begin
        prod    = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
        hi_d    = prod[2*WIDTH-1:WIDTH];
        lo_d    = prod[WIDTH-1:0];
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule

// File: tb/tb_mult_hilo_sequencer.sv
// Self-checking bench for mult_hilo_sequencer: directed vector table, interlock/flush/reset
// sequences, and randomized multiplies against an arithmetic reference model.
module tb_mult_hilo_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start_valid = 1'b0;
  logic         start_signed = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         flush = 1'b0;
  logic         mfhi_req = 1'b0;
  logic         mflo_req = 1'b0;
`ifdef MULT_HILO_MTHILO_EN
  logic         mthi_req = 1'b0;
  logic         mtlo_req = 1'b0;
  logic [W-1:0] mt_data = '0;
`endif
  logic [W-1:0] mf_data, hi, lo;
  logic         busy, stall, done;

  int checks = 0;
  int errors = 0;

  mult_hilo_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_signed(start_signed),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .mfhi_req(mfhi_req), .mflo_req(mflo_req),
`ifdef MULT_HILO_MTHILO_EN
    .mthi_req(mthi_req), .mtlo_req(mtlo_req), .mt_data(mt_data),
`endif
    .mf_data(mf_data), .hi(hi), .lo(lo),
    .busy(busy), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Product computed directly from the operands' numeric meaning.
  function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Present a start on the next falling edge; returns just after the accepting rising edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    start_valid  = 1'b1;
    start_signed = s;
    op_a         = a;
    op_b         = b;
    flush        = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Counts cycles after acceptance until done is seen (cycle 1 = first cycle after accept).
  task automatic wait_done(output int cyc);
    cyc = 1;
    forever begin
      @(negedge clk);
      if (done) break;
      @(posedge clk);
      cyc++;
      if (cyc > 100) begin
        chk("done_timeout", 64'(cyc), 64'(W + 1));
        break;
      end
    end
  endtask

  task automatic run_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int cyc;
    launch(a, b, s);
    start_valid = 1'b0;
    wait_done(cyc);
    chk({name, "_latency"}, 64'(cyc), 64'(W + 1));
    @(posedge clk);
    @(negedge clk);
    chk({name, "_hi"}, 64'(hi), 64'(ehi));
    chk({name, "_lo"}, 64'(lo), 64'(elo));
    chk({name, "_busy"}, 64'(busy), 64'd0);
    $display("mult a=%h b=%h s=%0d -> hi=%h lo=%h cycles=%0d", a, b, s, hi, lo, cyc);
  endtask

  initial begin
    int cyc;
    logic [63:0] p;
    logic [W-1:0] a, b, hold_hi, hold_lo;
    logic s;

    vecs[0] = '{32'd7,          32'd6,          1'b0, 32'h00000000, 32'h0000002A};
    vecs[1] = '{32'hFFFFFFFD,   32'd5,          1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'hFFFFFFFE, 32'h00000001};
    vecs[3] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 32'h00000000, 32'h00000001};
    vecs[4] = '{32'h80000000,   32'h80000000,   1'b1, 32'h40000000, 32'h00000000};
    vecs[5] = '{32'h80000000,   32'd1,          1'b1, 32'hFFFFFFFF, 32'h80000000};
    vecs[6] = '{32'h80000000,   32'h80000000,   1'b0, 32'h40000000, 32'h00000000};
    vecs[7] = '{32'd0,          32'h12345678,   1'b1, 32'h00000000, 32'h00000000};

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 8; i++)
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp_hi, vecs[i].exp_lo);

    // MFLO held from cycle 2 of MULTU 3x4: stalls through cycle 33, reads 0xC at cycle 34
    launch(32'd3, 32'd4, 1'b0);
    start_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    mflo_req = 1'b1;
    #1;
    for (int c = 2; c <= 33; c++) begin
      chk($sformatf("mf_stall_c%0d", c), 64'(stall), 64'd1);
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    chk("mf_stall_c34", 64'(stall), 64'd0);
    chk("mf_data_c34", 64'(mf_data), 64'h0000000C);
    $display("mflo after stall: mf_data=%h stall=%0d", mf_data, stall);
    mfhi_req = 1'b1;
    #1;
    chk("mf_hi_wins", 64'(mf_data), 64'd0);
    mflo_req = 1'b0;
    mfhi_req = 1'b0;

    // start with flush in IDLE: nothing accepted, HI/LO untouched
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start_valid = 1'b1;
      flush       = 1'b1;
      op_a        = 32'd5;
      op_b        = 32'd5;
      #1;
      chk("flush_idle_stall", 64'(stall), 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk("flush_idle_busy", 64'(busy), 64'd0);
      chk("flush_idle_lo", 64'(lo), 64'h0000000C);
      $display("flushed start: busy=%0d hi=%h lo=%h", busy, hi, lo);
    end
    start_valid = 1'b0;
    flush       = 1'b0;

    // flush while busy neither aborts nor stalls
    launch(32'd100, 32'd200, 1'b0);
    flush = 1'b1;
    op_a  = 32'd1;
    #1;
    chk("flush_busy_stall", 64'(stall), 64'd0);
    wait_done(cyc);
    chk("flush_busy_latency", 64'(cyc), 64'(W + 1));
    start_valid = 1'b0;
    flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("flush_busy_lo", 64'(lo), 64'd20000);
    $display("mult under flush: lo=%h", lo);

    // Back-to-back start: second waits, accepted in the first IDLE cycle
    launch(32'd11, 32'd13, 1'b0);
    op_a = 32'd2;
    op_b = 32'd21;
    wait_done(cyc);
    chk("b2b_first_latency", 64'(cyc), 64'(W + 1));
    chk("b2b_fix_stall", 64'(stall), 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_idle_stall", 64'(stall), 64'd0);
    chk("b2b_first_lo", 64'(lo), 64'd143);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    wait_done(cyc);
    chk("b2b_second_latency", 64'(cyc), 64'(W + 1));
    @(posedge clk);
    @(negedge clk);
    chk("b2b_second_lo", 64'(lo), 64'd42);
    $display("back-to-back: lo=%h", lo);

    // Async reset mid-multiply
    launch(32'd9, 32'd9, 1'b0);
    start_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    mflo_req = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_stall", 64'(stall), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    chk("midrst_mf", 64'(mf_data), 64'd0);
    mflo_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("postrst_busy", 64'(busy), 64'd0);
    chk("postrst_lo", 64'(lo), 64'd0);
    $display("after mid-op reset: busy=%0d lo=%h", busy, lo);

`ifdef MULT_HILO_MTHILO_EN
    @(negedge clk);
    mthi_req = 1'b1;
    mt_data  = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    mthi_req = 1'b0;
    chk("mthi", 64'(hi), 64'hDEADBEEF);
    mtlo_req = 1'b1;
    flush    = 1'b1;
    mt_data  = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    chk("mtlo_flushed", 64'(lo), 64'd0);
    flush = 1'b0;
    // start and MTLO together: start wins, LO not overwritten at acceptance
    launch(32'd6, 32'd7, 1'b0);
    start_valid = 1'b0;
    @(negedge clk);
    chk("mt_start_prio_lo", 64'(lo), 64'd0);
    chk("mt_busy_stall", 64'(stall), 64'd1);
    mtlo_req = 1'b0;
    wait_done(cyc);
    @(posedge clk);
    @(negedge clk);
    chk("mt_then_mult_lo", 64'(lo), 64'd42);
    $display("mt path: hi=%h lo=%h", hi, lo);
`endif

    // Randomized multiplies against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: a = 32'h80000000;
        1: b = 32'hFFFFFFFF;
        2: a = 32'd0;
        3: b = 32'h7FFFFFFF;
        default: ;
      endcase
      p = model(a, b, s);
      run_check($sformatf("rand%0d", i), a, b, s, p[63:32], p[31:0]);
    end

    hold_hi = hi;
    hold_lo = lo;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_hold_hi", 64'(hi), 64'(hold_hi));
    chk("idle_hold_lo", 64'(lo), 64'(hold_lo));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
